neuron_unit: RTL
================

Name: neuron_unit

Overview:
- Per-unit weighted-sum engine; one instance sits on each weight/write lane of the RAM mux (weightN/writeN).
- Captures streamed weight bytes into a local buffer, then runs a serial multiply-accumulate on sum_trigger from the RAM read driver.
- Produces a saturated 8-bit activation and a done pulse that the network controller consumes.

Parameters:
- N_INPUTS, 3, number of synaptic inputs; the buffer holds N_INPUTS weights plus 1 bias.
- FRAC_BITS, 6, fractional bits of signed fixed-point weights and inputs (64 = 1.0).
- ACC_W, 20, accumulator width in bits; must be at least 16+clog2(N_INPUTS+1)+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- weight  in  8  signed weight byte from the RAM mux lane.
- write  in  1  single-cycle strobe; capture weight at the current write pointer.
- sum_trigger  in  1  start request from the read driver; rising edge is detected internally.
- x_in  in  8*N_INPUTS  signed inputs, packed; x[i] = x_in[8i+7:8i]; must be held stable while busy.
- y_out  out  8  signed saturated result, held until the next result.
- y_valid  out  1  one-cycle pulse when y_out updates; drives the controller done.
- busy  out  1  high from edge detection through the y_valid cycle.
- wr_count  out  clog2(N_INPUTS+2)  number of weights loaded since last clear.
- wr_err  out  1  sticky; write received while busy. Cleared only by reset.

Behaviour:
- Reset (reset=0, async) values:
  - FSM = IDLE; y_out, y_valid, busy, wr_count, wr_err, accumulator, index all 0.
  - Weight buffer contents are not reset.
- Weight load, IDLE only:
  - On write=1, buf[wr_ptr] <= weight and wr_ptr increments.
  - Index N_INPUTS holds the bias.
  - wr_ptr wraps from N_INPUTS to 0.
  - wr_count saturates at N_INPUTS+1.
- Write while busy: write ignored, wr_err <= 1.
- Trigger detection:
  - A registered copy of sum_trigger is kept; an edge is current=1 and previous=0.
  - An edge seen outside IDLE is ignored and not queued.
- FSM: IDLE -> MAC -> BIAS -> OUT -> IDLE.
  - IDLE: on edge, acc <= 0, idx <= 0, busy <= 1, go to MAC.
  - MAC: acc <= acc + sext(buf[idx]*x[idx]) (signed 8x8 -> 16). idx increments. After idx = N_INPUTS-1, go to BIAS. Takes exactly N_INPUTS cycles.
  - BIAS: acc <= acc + (sext(buf[N_INPUTS]) <<< FRAC_BITS).
  - OUT:
    - r = acc >>> FRAC_BITS (arithmetic shift, truncation toward minus infinity).
    - Saturate r to [-128, 127]; y_out <= result.
    - y_valid = 1 for this cycle.
    - wr_ptr <= 0 and wr_count <= 0, so the next layer loads fresh.
    - busy drops on the following cycle.
- Latency: edge sampled at cycle k -> y_valid at cycle k+N_INPUTS+2.
- Edge on the same cycle as the OUT state: ignored. A new edge is needed after IDLE is reached.
- Write and trigger edge in the same IDLE cycle: the write is captured first, and the MAC uses the updated buffer.
- Reset asserted mid-operation: immediate abort, all outputs return to reset values, and no y_valid is produced.
- Loading fewer than N_INPUTS+1 weights is legal. Stale buffer entries are used; the bench checks wr_count.

Optional Feature:
- Macro NEURON_RELU_EN.
- Defined: in OUT, a negative saturated result is replaced by 0, so y_out is in [0, 127].
- Undefined: y_out is the signed saturated value in [-128, 127].
- Latency is identical in both builds.

Decomposition:
- Shared package neural_pkg:
  - WEIGHT_W=8, DATA_W=8, FRAC_BITS default.
  - The FSM state enum (IDLE, MAC, BIAS, OUT).
  - A saturate8 function.
- Sub-module mac_datapath: signed multiplier, accumulator, shift/saturate/ReLU stage.
- The FSM, edge detector, and weight buffer stay in neuron_unit.

Test Plan:
- Basic weighted sum:
  - Stimulus: write 64, 64, 64, then bias 0; x = 10, 20, 30; pulse sum_trigger.
  - Response: y_out = 60, y_valid exactly 5 cycles after the sampled edge, wr_count then 0.
- Positive saturation:
  - Stimulus: weights 127, 127, 127, bias 127; x = 127, 127, 127.
  - Response: y_out = 127.
- Negative result and ReLU:
  - Stimulus: weights -128, -128, -128, bias 0; x = 127, 127, 127.
  - Response: y_out = -128 without the macro, 0 with NEURON_RELU_EN.
- Bias only:
  - Stimulus: weights 0, 0, 0, bias -5; any x.
  - Response: y_out = -5, or 0 with NEURON_RELU_EN.
- Busy-time protection:
  - Stimulus: write pulse and a second sum_trigger edge during MAC.
  - Response: wr_err = 1, buffer unchanged, exactly one y_valid.
- Reset mid-operation:
  - Stimulus: drive reset low during MAC cycle 2.
  - Response: busy = 0, y_out = 0, no y_valid. The next full load and trigger gives the correct result.

Source files
------------

// File: rtl/neural_pkg.sv
// Shared types and helpers for the neural datapath blocks.
//   WEIGHT_W / DATA_W : byte widths of weights and activations
//   FRAC_BITS         : default fractional bits of the fixed-point format (64 = 1.0)
//   state_e           : neuron sequencing states
//   saturate8         : clamp a signed value to the 8-bit range [-128, 127]
package neural_pkg;

    localparam int WEIGHT_W  = 8;
    localparam int DATA_W    = 8;
    localparam int FRAC_BITS = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        BIAS = 2'd2,
        OUT  = 2'd3
    } state_e;

    function automatic logic signed [7:0] saturate8(input logic signed [31:0] v);
        if (v > 32'sd127)
            return 8'sd127;
        else if (v < -32'sd128)
            return 8'h80;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/mac_datapath.sv
// Serial multiply-accumulate datapath of one neuron.
//   clk, rst_n  : clock, async active-low reset (clears the accumulator)
//   clr_i       : zero the accumulator
//   mac_en_i    : acc += sext(w_i * x_i)
//   bias_en_i   : acc += sext(b_i) <<< FRAC_BITS
//   y_o         : saturated (optionally rectified) activation of the NEXT
//                 accumulator value, so the caller can register it on the
//                 same edge that adds the bias.
// Build option: NEURON_RELU_EN clamps negative activations to 0.
module mac_datapath #(
    parameter int ACC_W     = 20,
    parameter int FRAC_BITS = neural_pkg::FRAC_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              mac_en_i,
    input  logic              bias_en_i,
    input  logic signed [7:0] w_i,
    input  logic signed [7:0] x_i,
    input  logic signed [7:0] b_i,
    output logic signed [7:0] y_o
);
    import neural_pkg::*;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] shifted;
    logic signed [7:0]       sat;

    assign prod     = w_i * x_i;
    assign bias_ext = ACC_W'(b_i) <<< FRAC_BITS;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (mac_en_i)
            acc_d = acc_q + ACC_W'(prod);
        else if (bias_en_i)
            acc_d = acc_q + bias_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    // Arithmetic shift floors toward minus infinity.
    assign shifted = acc_d >>> FRAC_BITS;
    assign sat     = saturate8(32'(shifted));

`ifdef NEURON_RELU_EN
    assign y_o = sat[7] ? 8'sd0 : sat;
`else
    assign y_o = sat;
`endif

endmodule

// File: rtl/neuron_unit.sv
// Weighted-sum neuron: captures streamed weight bytes (N_INPUTS weights then
// a bias), and on a rising edge of sum_trigger runs a serial MAC, adds the
// bias and emits a saturated 8-bit activation with a one-cycle y_valid.
//   clk, reset   : clock, async active-low reset
//   weight/write : weight byte and capture strobe (IDLE only)
//   sum_trigger  : start request, edge-detected internally
//   x_in         : packed signed inputs, held stable while busy
//   y_out/y_valid: result and its update pulse
//   busy         : edge accepted through the y_valid cycle
//   wr_count     : weights loaded since last clear (saturating)
//   wr_err       : sticky, write attempted while busy
// Build option: NEURON_RELU_EN (see mac_datapath) rectifies the result.
module neuron_unit #(
    parameter int  N_INPUTS  = 3,
    parameter int  FRAC_BITS = neural_pkg::FRAC_BITS,
    parameter int  ACC_W     = 20,
    localparam int WC_W      = $clog2(N_INPUTS + 2)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [7:0]       weight,
    input  logic                    write,
    input  logic                    sum_trigger,
    input  logic [8*N_INPUTS-1:0]   x_in,
    output logic signed [7:0]       y_out,
    output logic                    y_valid,
    output logic                    busy,
    output logic [WC_W-1:0]         wr_count,
    output logic                    wr_err
);
    import neural_pkg::*;

    localparam int PTR_W = $clog2(N_INPUTS + 1);
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    state_e              state_q, state_d;
    logic                trig_q;
    logic                trig_edge;
    logic [IDX_W-1:0]    idx_q;
    logic                busy_q;
    logic                y_valid_q;
    logic signed [7:0]   y_out_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [WC_W-1:0]     wr_count_q;
    logic                wr_err_q;
    logic signed [7:0]   wbuf_q [N_INPUTS+1];
    logic signed [7:0]   x_arr  [N_INPUTS];
    logic signed [7:0]   y_dp;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_x
        assign x_arr[g] = x_in[8*g +: 8];
    end

    assign trig_edge = sum_trigger & ~trig_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (trig_edge) state_d = MAC;
            MAC:  if (idx_q == IDX_W'(N_INPUTS - 1)) state_d = BIAS;
            BIAS: state_d = OUT;
            OUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            trig_q     <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            y_valid_q  <= 1'b0;
            y_out_q    <= '0;
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            trig_q    <= sum_trigger;
            // Result is registered on the BIAS->OUT edge, so it is visible
            // during the OUT cycle together with y_valid.
            y_valid_q <= (state_q == BIAS);
            if (state_q == BIAS)
                y_out_q <= y_dp;

            case (state_q)
                IDLE: if (trig_edge) begin
                    busy_q <= 1'b1;
                    idx_q  <= '0;
                end
                MAC:  idx_q <= idx_q + 1'b1;
                OUT: begin
                    busy_q     <= 1'b0;
                    wr_ptr_q   <= '0;
                    wr_count_q <= '0;
                end
                default: ;
            endcase

            if (write) begin
                if (state_q == IDLE) begin
                    wr_ptr_q <= (wr_ptr_q == PTR_W'(N_INPUTS)) ? '0 : wr_ptr_q + 1'b1;
                    if (wr_count_q != WC_W'(N_INPUTS + 1))
                        wr_count_q <= wr_count_q + 1'b1;
                end else begin
                    wr_err_q <= 1'b1;
                end
            end
        end
    end

    // Weight storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (write && state_q == IDLE)
            wbuf_q[wr_ptr_q] <= weight;
    end

    mac_datapath #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_dp (
        .clk       (clk),
        .rst_n     (reset),
        .clr_i     (state_q == IDLE && trig_edge),
        .mac_en_i  (state_q == MAC),
        .bias_en_i (state_q == BIAS),
        .w_i       (wbuf_q[idx_q]),
        .x_i       (x_arr[idx_q]),
        .b_i       (wbuf_q[N_INPUTS]),
        .y_o       (y_dp)
    );

    assign y_out    = y_out_q;
    assign y_valid  = y_valid_q;
    assign busy     = busy_q;
    assign wr_count = wr_count_q;
    assign wr_err   = wr_err_q;

endmodule
